multi_channel_fanout: RTL

Parametrised, registered successor to the team's primitive-based multi-output gate. It distributes one asynchronous input `din` to `CH_NUM` output channels. Each channel is configured at run time as buffer, inverter, toggle or edge-pulse. The input passes through a synchroniser and a programmable debounce filter before fan-out, so the block is used directly on board-level pins (keys, switches) that feed several downstream consumers.

---
 rtl/multi_channel_fanout.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multi_channel_fanout.sv
// Synchronised, debounced single-input fan-out to CH_NUM registered channels,
// each configurable at run time as buffer, inverter, toggle or edge-pulse.
module multi_channel_fanout #(
  parameter int CH_NUM      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4,
  parameter int CH_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic [DEB_W-1:0]  deb_len,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  output logic [CH_NUM-1:0] dout,
  output logic              d_stb,
  output logic              d_rise,
  output logic              d_fall,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    MODE_BUF    = 2'b00,
    MODE_NOT    = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic [DEB_W-1:0]       cnt_r;
  logic                   stb_r;
  logic                   rise_evt_r;
  logic                   fall_evt_r;
  mode_t                  mode_r [CH_NUM];
  logic [CH_NUM-1:0]      dout_r;
  logic [CH_NUM-1:0]      dout_nxt_s;
  logic [CH_NUM-1:0]      wr_hit_s;
  logic                   cfg_legal_s;
  logic                   d_rise_r;
  logic                   d_fall_r;
  logic                   cfg_err_r;

  assign s_s         = sync_r[SYNC_STAGES-1];
  assign cfg_legal_s = ({1'b0, cfg_ch} < (CH_W+1)'(CH_NUM));

  // Per-channel write decode
  always_comb begin
    wr_hit_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_wr && (cfg_ch == CH_W'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Next channel outputs; a write on a channel clears it and drops that edge's event
  always_comb begin
    dout_nxt_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (wr_hit_s[i]) begin
        dout_nxt_s[i] = 1'b0;
      end else begin
        case (mode_r[i])
          MODE_BUF:    dout_nxt_s[i] = stb_r;
          MODE_NOT:    dout_nxt_s[i] = ~stb_r;
          MODE_TOGGLE: dout_nxt_s[i] = dout_r[i] ^ rise_evt_r;
          MODE_PULSE:  dout_nxt_s[i] = rise_evt_r;
          default:     dout_nxt_s[i] = 1'b0;
        endcase
      end
    end
  end

  // Input synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce: accept a new level after deb_len+1 consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      stb_r      <= 1'b0;
      rise_evt_r <= 1'b0;
      fall_evt_r <= 1'b0;
    end else if (s_s != stb_r) begin
      if (cnt_r >= deb_len) begin
        stb_r      <= s_s;
        cnt_r      <= '0;
        rise_evt_r <= s_s;
        fall_evt_r <= ~s_s;
      end else begin
        cnt_r      <= cnt_r + DEB_W'(1);
        rise_evt_r <= 1'b0;
        fall_evt_r <= 1'b0;
      end
    end else begin
      cnt_r      <= '0;
      rise_evt_r <= 1'b0;
      fall_evt_r <= 1'b0;
    end
  end

  // Channel modes and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r    <= '0;
      d_rise_r  <= 1'b0;
      d_fall_r  <= 1'b0;
      cfg_err_r <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        mode_r[i] <= MODE_BUF;
      end
    end else begin
      dout_r    <= dout_nxt_s;
      d_rise_r  <= rise_evt_r;
      d_fall_r  <= fall_evt_r;
      cfg_err_r <= cfg_wr & ~cfg_legal_s;
      for (int i = 0; i < CH_NUM; i++) begin
        if (wr_hit_s[i]) begin
          mode_r[i] <= mode_t'(cfg_mode);
        end
      end
    end
  end

  assign dout    = dout_r;
  assign d_stb   = stb_r;
  assign d_rise  = d_rise_r;
  assign d_fall  = d_fall_r;
  assign cfg_err = cfg_err_r;

endmodule
